// File: rtl/fifo_in_pkg.sv
// Shared sizes and types for the AES input word-packing buffer.
package fifo_in_pkg;
  localparam int WORD_W    = 32;
  localparam int NUM_WORDS = 4;
  localparam int BLOCK_W   = WORD_W * NUM_WORDS;
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;
  typedef logic [CNT_W-1:0]   cnt_t;
endpackage

// File: rtl/fifo_in.sv
// Packs four 32-bit words (first word most significant) into one 128-bit block
// and hands it to a registered output on read.
module fifo_in
  import fifo_in_pkg::*;
(
  input  logic         clk,
  input  logic         n_rst,
  input  logic         write_en,
  input  logic         read_en,
  input  logic [31:0]  data_in,
  output logic         fifo_empty,
  output logic         fifo_full,
  output logic [127:0] data_out
);

  // Strobe semantics: a write is taken on any edge where write_en=1 and the
  // buffer is not full; a read is taken only when read_en=1 and it is full.
  // Read+write while full retires the block and starts the next one with data_in.
  cnt_t   count;
  block_t pack_q;
  block_t data_q;
  logic   is_full;
  logic   wr_ok;
  logic   rd_ok;

  assign is_full = (count == cnt_t'(NUM_WORDS));
  assign wr_ok   = write_en && !is_full;
  assign rd_ok   = read_en && is_full;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count  <= '0;
      pack_q <= '0;
      data_q <= '0;
    end else if (rd_ok) begin
      data_q <= pack_q;
      if (write_en) begin
        pack_q[BLOCK_W-1 -: WORD_W] <= data_in;
        count <= cnt_t'(1);
      end else begin
        count <= '0;
      end
    end else if (wr_ok) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (count == cnt_t'(i)) begin
          pack_q[BLOCK_W-1-i*WORD_W -: WORD_W] <= data_in;
        end
      end
      count <= count + cnt_t'(1);
    end
  end

  assign fifo_empty = (count == '0);
  assign fifo_full  = is_full;
  assign data_out   = data_q;

endmodule

// File: tb/tb_fifo_in.sv
// Randomized and directed bench for fifo_in against a word-queue reference model.
module tb_fifo_in;
  import fifo_in_pkg::*;

  logic         clk;
  logic         n_rst;
  logic         write_en;
  logic         read_en;
  logic [31:0]  data_in;
  logic         fifo_empty;
  logic         fifo_full;
  logic [127:0] data_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  words[$];
  logic [127:0] exp_q[$];
  logic [127:0] exp_data;
  logic [127:0] tmp;

  fifo_in dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .write_en   (write_en),
    .read_en    (read_en),
    .data_in    (data_in),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .data_out   (data_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] pack_words();
    logic [127:0] b = '0;
    foreach (words[i]) b = (b << 32) | 128'(words[i]);
    return b;
  endfunction

  task automatic check_all();
    check("empty", 128'(fifo_empty), 128'(words.size() == 0));
    check("full", 128'(fifo_full), 128'(words.size() == NUM_WORDS));
    check("data_out", data_out, exp_data);
  endtask

  // driver: one clock cycle with the given strobes; model updated from pre-edge state
  task automatic step(input logic we, input logic re, input logic [31:0] din);
    logic full_m;
    full_m   = (words.size() == NUM_WORDS);
    write_en = we;
    read_en  = re;
    data_in  = din;
    if (re && full_m) begin
      exp_data = pack_words();
      exp_q.push_back(exp_data);
      words.delete();
      if (we) words.push_back(din);
    end else if (we && !full_m) begin
      words.push_back(din);
    end
    @(posedge clk);
    #1;
    write_en = 1'b0;
    read_en  = 1'b0;
    check_all();
    if (re && full_m) begin
      if (exp_q.size() == 0) check("scoreboard_empty", 128'(1), 128'(0));
      else check("read_block", data_out, exp_q.pop_front());
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    words.delete();
    exp_data = '0;
    check_all();
  endtask

  task automatic write_block(input logic [31:0] w0, input logic [31:0] w1,
                             input logic [31:0] w2, input logic [31:0] w3);
    step(1'b1, 1'b0, w0); step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, w1); step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, w2); step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, w3);
  endtask

  initial begin
    n_rst = 1'b0; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    exp_data = '0;
    @(posedge clk); #1;
    do_reset();
    step(1'b0, 1'b0, '0);

    // basic fill and read
    write_block(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
    check("full_after_4th", 128'(fifo_full), 128'(1));
    step(1'b0, 1'b1, '0);
    check("block_abcd", data_out, 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD);
    check("empty_after_read", 128'(fifo_empty), 128'(1));
    step(1'b0, 1'b0, '0);

    // write while full is dropped
    write_block(32'h12345678, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
    step(1'b1, 1'b0, 32'hEEEEEEEE);
    step(1'b0, 1'b1, '0);
    check("block_drop", data_out, 128'h12345678BBBBBBBBCCCCCCCCDDDDDDDD);

    // refill shows no residue
    write_block(32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD);
    step(1'b0, 1'b1, '0);
    check("block_refill", data_out, 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD);

    // partial read ignored, then reset clears
    step(1'b1, 1'b0, 32'h01010101);
    step(1'b1, 1'b0, 32'h02020202);
    step(1'b0, 1'b1, '0);
    check("partial_hold", data_out, 128'hAAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD);
    do_reset();
    check("reset_data", data_out, 128'h0);

    // simultaneous read+write while full
    write_block(32'h0A0A0A0A, 32'h0B0B0B0B, 32'h0C0C0C0C, 32'h0D0D0D0D);
    step(1'b1, 1'b1, 32'h11111111);
    check("rw_block", data_out, 128'h0A0A0A0A0B0B0B0B0C0C0C0C0D0D0D0D);
    check("rw_not_empty", 128'(fifo_empty), 128'(0));
    step(1'b1, 1'b0, 32'h22222222);
    step(1'b1, 1'b0, 32'h33333333);
    step(1'b1, 1'b0, 32'h44444444);
    step(1'b0, 1'b1, '0);
    tmp = data_out;
    check("rw_slot0", 128'(tmp[127:96]), 128'(32'h11111111));

    // random traffic, including mid-fill resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 35), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fifo_in.md
Name: fifo_in

Overview:
- Input-side word-packing buffer for the AES-128 datapath.
- Accepts 32-bit words one at a time and assembles four of them into one 128-bit block.
- Raises fifo_full when a complete block is held; a read transfers the block to the registered 128-bit output and empties the buffer.
- Sits between the host/bus interface and the AES core's block input.

Parameters:
- WORD_W, 32, width of one input word.
- NUM_WORDS, 4, words per output block; output width = WORD_W*NUM_WORDS = 128.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- n_rst  input  1  reset, synchronous, active-low.
- write_en  input  1  write strobe; one word accepted per cycle when asserted and not full.
- read_en  input  1  read strobe; transfers the held block when full.
- data_in  input  32  input word.
- fifo_empty  output  1  high when zero words are held.
- fifo_full  output  1  high when NUM_WORDS words are held.
- data_out  output  128  last block read out; registered.

Behaviour:
- Reset (n_rst low at a rising edge):
  - word count = 0, storage = 0, data_out = 0.
  - fifo_empty = 1, fifo_full = 0.
  - Reset mid-fill discards the partial block.
- State:
  - 128-bit packing register.
  - Word counter 0..NUM_WORDS; 3 bits for the default.
- Write:
  - Condition: write_en=1 and count<NUM_WORDS at a rising edge.
  - data_in is stored in slot[count] and count increments.
  - Slot 0 (first word written) occupies data bits [127:96]; slot 3 (last word) occupies [31:0]. The first word is the most significant.
- Write while full (count==NUM_WORDS, no read):
  - Word dropped; storage, count and flags unchanged. No error flag.
- Read:
  - Condition: read_en=1 and count==NUM_WORDS at a rising edge.
  - data_out <= packing register and count <= 0.
  - fifo_empty and fifo_full reflect the new count after that same edge.
  - data_out then holds its value until the next successful read or reset.
- Read while not full: ignored; data_out, count and storage unchanged. Partial blocks are never emitted.
- Simultaneous read_en and write_en while full:
  - The read succeeds.
  - The incoming word is written into slot 0 of the next block; count becomes 1.
- Simultaneous read_en and write_en while not full: the write proceeds and the read is ignored.
- Flags:
  - fifo_empty = (count==0); fifo_full = (count==NUM_WORDS).
  - Both are combinational decodes of the registered count, so they are valid in the same cycle after the edge that changes count.
- Latency:
  - fifo_full rises right after the edge that accepts the 4th word.
  - data_out is valid right after the read edge.
- Stale slot contents are not cleared on read. They are always overwritten before the next full block.

Decomposition:
- Shared package (aes_pkg or equivalent) holds:
  - WORD_W=32, NUM_WORDS=4, BLOCK_W=128.
  - Typedefs word_t (logic [31:0]) and block_t (logic [127:0]).
- No sub-module; the counter and packing register stay in fifo_in.

Test Plan:
- Reset then idle one cycle -> fifo_empty=1, fifo_full=0, data_out=0.
- Write AAAAAAAA, BBBBBBBB, CCCCCCCC, DDDDDDDD (write_en pulsed with idle cycles between) -> fifo_full=1 after 4th write edge; read_en one cycle -> data_out=AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD, fifo_empty=1 immediately after the read edge and on the following cycle.
- Write 12345678, BBBBBBBB, CCCCCCCC, DDDDDDDD -> full; write EEEEEEEE while full (dropped); read -> data_out=12345678BBBBBBBBCCCCCCCCDDDDDDDD, fifo_empty=1.
- Refill with AAAAAAAA..DDDDDDDD after a prior block -> full=1, read gives AAAAAAAABBBBBBBBCCCCCCCCDDDDDDDD, empty=1 (no residue from the earlier block).
- Write 2 words then read_en -> read ignored: data_out keeps its previous value, fifo_empty=0, fifo_full=0. Pulse n_rst low -> empty=1, data_out=0.
- With the buffer full, assert read_en and write_en together with data_in=11111111 -> data_out=previous block, count=1 (empty=0, full=0). Three more writes give full, and the next read has 11111111 in [127:96].
